// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: branch type codes, BHT counter
// states and the branch condition function.
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BGE  = 3'b011;
    localparam logic [2:0] BR_BLE  = 3'b100;
    localparam logic [2:0] BR_BGT  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_JMP  = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic br_taken(input logic [2:0] br, input logic zero,
                                      input logic overflow, input logic negative);
        logic t;
        case (br)
            BR_BEQ:  t = zero & ~overflow;
            BR_BNE:  t = ~zero;
            BR_BGE:  t = zero | ~negative;
            BR_BLE:  t = zero | negative;
            BR_BGT:  t = ~zero & ~negative;
            BR_BLT:  t = ~zero & negative;
            BR_JMP:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table: 2-bit saturating counters, one combinational read port
// and one saturating-update write port.
module bht_table
    import branch_pkg::*;
#(
    parameter int         BHT_DEPTH  = 64,
    parameter logic [1:0] INIT_STATE = WNT,
    localparam int        IDX_W      = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_state,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] table_q [BHT_DEPTH];

    function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
        logic [1:0] next;
        if (taken)
            next = (state == ST) ? ST : state + 2'd1;
        else
            next = (state == SNT) ? SNT : state - 2'd1;
        return next;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                table_q[i] <= INIT_STATE;
        end else if (wr_en) begin
            table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
        end
    end

    // No bypass: a same-cycle read sees the value before this cycle's update.
    assign rd_state = table_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: evaluates branch conditions, registers the PC-source
// decision, flags mispredicts with a one-cycle redirect and keeps statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         BHT_DEPTH  = 64,
    parameter int         CNT_W      = 16,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [2:0]        res_branch,
    input  logic              res_zero,
    input  logic              res_overflow,
    input  logic              res_negative,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_target,
    input  logic [ADDR_W-1:0] res_fallthrough,
    output logic              pcsrc,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       pred_state;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[ADDR_W-1:IDX_W+2], pred_pc[1:0],
                              res_pc[ADDR_W-1:IDX_W+2], res_pc[1:0]};

    // Stage p0: condition evaluation on the resolving branch
    logic vld_p0;
    logic taken_p0;
    logic mispredict_p0;

    assign vld_p0        = res_valid && (res_branch != BR_NONE);
    assign taken_p0      = br_taken(res_branch, res_zero, res_overflow, res_negative);
    assign mispredict_p0 = vld_p0 && (taken_p0 != res_pred_taken);

    bht_table #(
        .BHT_DEPTH  (BHT_DEPTH),
        .INIT_STATE (INIT_STATE)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_idx),
        .rd_state (pred_state),
        .wr_en    (vld_p0),
        .wr_idx   (res_idx),
        .wr_taken (taken_p0)
    );

    assign pred_taken = pred_valid & pred_state[1];

    // Stage p1: registered decision, redirect and statistics
    logic              pcsrc_p1;
    logic              redirect_p1;
    logic [ADDR_W-1:0] redirect_pc_p1;
    logic [CNT_W-1:0]  branch_count_p1;
    logic [CNT_W-1:0]  mispredict_count_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcsrc_p1            <= 1'b0;
            redirect_p1         <= 1'b0;
            redirect_pc_p1      <= '0;
            branch_count_p1     <= '0;
            mispredict_count_p1 <= '0;
        end else begin
            pcsrc_p1    <= vld_p0 & taken_p0;
            redirect_p1 <= mispredict_p0;
            // redirect_pc only moves on a mispredict so it holds otherwise
            if (mispredict_p0)
                redirect_pc_p1 <= taken_p0 ? res_target : res_fallthrough;
            if (vld_p0)
                branch_count_p1 <= sat_inc(branch_count_p1);
            if (mispredict_p0)
                mispredict_count_p1 <= sat_inc(mispredict_count_p1);
        end
    end

    assign pcsrc            = pcsrc_p1;
    assign redirect         = redirect_p1;
    assign redirect_pc      = redirect_pc_p1;
    assign branch_count     = branch_count_p1;
    assign mispredict_count = mispredict_count_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with CNT_W=4 so counter saturation is reachable.
module tb_branch_resolve_unit;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_pc;
    logic              pred_taken;
    logic              res_valid;
    logic [ADDR_W-1:0] res_pc;
    logic [2:0]        res_branch;
    logic              res_zero;
    logic              res_overflow;
    logic              res_negative;
    logic              res_pred_taken;
    logic [ADDR_W-1:0] res_target;
    logic [ADDR_W-1:0] res_fallthrough;
    logic              pcsrc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(
        .ADDR_W     (ADDR_W),
        .BHT_DEPTH  (64),
        .CNT_W      (CNT_W),
        .INIT_STATE (2'b01)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_pc           (res_pc),
        .res_branch       (res_branch),
        .res_zero         (res_zero),
        .res_overflow     (res_overflow),
        .res_negative     (res_negative),
        .res_pred_taken   (res_pred_taken),
        .res_target       (res_target),
        .res_fallthrough  (res_fallthrough),
        .pcsrc            (pcsrc),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one resolve and advance past the sampling edge; inputs stay applied.
    task automatic resolve(input logic [2:0] br, input logic z, input logic o, input logic n,
                           input logic pt, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [31:0] ft);
        res_valid       = 1'b1;
        res_branch      = br;
        res_zero        = z;
        res_overflow    = o;
        res_negative    = n;
        res_pred_taken  = pt;
        res_pc          = pc;
        res_target      = tgt;
        res_fallthrough = ft;
        tick();
    endtask

    task automatic idle();
        res_valid  = 1'b0;
        res_branch = 3'b000;
        tick();
    endtask

    initial begin
        rst = 1'b1; pred_valid = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_pc = '0; res_branch = 3'b000;
        res_zero = 1'b0; res_overflow = 1'b0; res_negative = 1'b0; res_pred_taken = 1'b0;
        res_target = '0; res_fallthrough = '0;
        tick(); tick();
        rst = 1'b0;
        pred_valid = 1'b1; pred_pc = 32'h100;
        #1;
        check("rst_pred_taken", {31'b0, pred_taken}, 32'd0);
        check("rst_pcsrc", {31'b0, pcsrc}, 32'd0);
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_count", {28'b0, branch_count}, 32'd0);
        check("rst_mispredict_count", {28'b0, mispredict_count}, 32'd0);

        // BEQ taken, predicted not-taken: mispredict to target
        resolve(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h200, 32'h104);
        check("beq_pcsrc", {31'b0, pcsrc}, 32'd1);
        check("beq_redirect", {31'b0, redirect}, 32'd1);
        check("beq_redirect_pc", redirect_pc, 32'h200);
        check("beq_branch_count", {28'b0, branch_count}, 32'd1);
        check("beq_mispredict_count", {28'b0, mispredict_count}, 32'd1);
        check("beq_pred_wt", {31'b0, pred_taken}, 32'd1);
        idle();
        check("pulse_redirect_low", {31'b0, redirect}, 32'd0);
        check("idle_pcsrc", {31'b0, pcsrc}, 32'd0);
        check("held_redirect_pc", redirect_pc, 32'h200);

        // Two more taken resolves saturate the entry at 11
        resolve(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'h104);
        check("beq2_redirect", {31'b0, redirect}, 32'd0);
        resolve(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'h104);
        check("beq3_branch_count", {28'b0, branch_count}, 32'd3);
        check("beq3_mispredict_count", {28'b0, mispredict_count}, 32'd1);
        check("st_pred_taken", {31'b0, pred_taken}, 32'd1);
        pred_valid = 1'b0;
        #1;
        check("pred_valid_low", {31'b0, pred_taken}, 32'd0);
        pred_valid = 1'b1;

        // Four not-taken BNE resolves: consecutive redirects, entry down to 00
        for (int i = 0; i < 4; i++) begin
            resolve(3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h200, 32'h1000 + 32'(i) * 4);
            check("bne_redirect", {31'b0, redirect}, 32'd1);
            check("bne_redirect_pc", redirect_pc, 32'h1000 + 32'(i) * 4);
            check("bne_pcsrc", {31'b0, pcsrc}, 32'd0);
        end
        check("bne_branch_count", {28'b0, branch_count}, 32'd7);
        check("bne_mispredict_count", {28'b0, mispredict_count}, 32'd5);
        check("snt_pred_taken", {31'b0, pred_taken}, 32'd0);

        // Back-to-back BGT (correct taken) then BLT (mispredicted not-taken)
        resolve(3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 32'h180, 32'h300, 32'h184);
        check("bgt_pcsrc", {31'b0, pcsrc}, 32'd1);
        check("bgt_redirect", {31'b0, redirect}, 32'd0);
        resolve(3'b110, 1'b1, 1'b0, 1'b1, 1'b1, 32'h184, 32'h400, 32'h188);
        check("blt_pcsrc", {31'b0, pcsrc}, 32'd0);
        check("blt_redirect", {31'b0, redirect}, 32'd1);
        check("blt_redirect_pc", redirect_pc, 32'h188);
        check("blt_branch_count", {28'b0, branch_count}, 32'd9);
        check("blt_mispredict_count", {28'b0, mispredict_count}, 32'd6);

        // Same-cycle read/write at 0x40: old value now, updated value next cycle
        pred_pc = 32'h40;
        res_valid = 1'b1; res_branch = 3'b111; res_pc = 32'h40;
        res_pred_taken = 1'b0; res_target = 32'h500; res_fallthrough = 32'h44;
        #1;
        check("same_cycle_old", {31'b0, pred_taken}, 32'd0);
        tick();
        check("same_cycle_new", {31'b0, pred_taken}, 32'd1);
        check("jmp_redirect_pc", redirect_pc, 32'h500);
        check("jmp_branch_count", {28'b0, branch_count}, 32'd10);
        idle();

        // Fresh reset, then non-branches and invalid resolves do not count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_bht_0x40", {31'b0, pred_taken}, 32'd0);
        for (int i = 0; i < 20; i++)
            resolve(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h600, 32'h84);
        check("none_branch_count", {28'b0, branch_count}, 32'd0);
        check("none_redirect", {31'b0, redirect}, 32'd0);
        res_valid = 1'b0; res_branch = 3'b111;
        tick();
        check("invalid_branch_count", {28'b0, branch_count}, 32'd0);
        check("invalid_pcsrc", {31'b0, pcsrc}, 32'd0);

        // 20 mispredicted JMPs saturate both 4-bit counters
        pred_pc = 32'h80;
        for (int i = 0; i < 20; i++)
            resolve(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h700, 32'h84);
        check("sat_branch_count", {28'b0, branch_count}, 32'd15);
        check("sat_mispredict_count", {28'b0, mispredict_count}, 32'd15);
        check("sat_redirect", {31'b0, redirect}, 32'd1);
        check("sat_redirect_pc", redirect_pc, 32'h700);
        check("sat_pred_0x80", {31'b0, pred_taken}, 32'd1);

        // Reset with a mispredict being resolved drops the redirect
        rst = 1'b1;
        resolve(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h800, 32'h84);
        rst = 1'b0;
        res_valid = 1'b0; res_branch = 3'b000;
        #1;
        check("rst_mid_redirect", {31'b0, redirect}, 32'd0);
        check("rst_mid_pcsrc", {31'b0, pcsrc}, 32'd0);
        check("rst_mid_redirect_pc", redirect_pc, 32'h0);
        check("rst_mid_branch_count", {28'b0, branch_count}, 32'd0);
        check("rst_mid_mispredict_count", {28'b0, mispredict_count}, 32'd0);
        check("rst_mid_pred_0x80", {31'b0, pred_taken}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch decision block for the MIPS pipeline; replaces the purely combinational PC-source select.
- Evaluates branch conditions from ALU flags and registers the PC-source decision.
- Holds a parametrised branch history table (BHT) of 2-bit saturating counters, giving fetch a taken/not-taken prediction.
- At resolve time, detects mispredicts and issues a one-cycle redirect/flush with the corrected PC; keeps saturating branch and mispredict statistics.

Parameters:
ADDR_W, 32, width of PC and target addresses
BHT_DEPTH, 64, number of BHT entries; power of two, >= 2
CNT_W, 16, width of the statistics counters
INIT_STATE, 2'b01, BHT entry value after reset (weakly not-taken)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
pred_valid  input  1  fetch lookup request
pred_pc  input  ADDR_W  PC of fetched instruction
pred_taken  output  1  predicted taken; combinational from registered table
res_valid  input  1  branch resolving this cycle
res_pc  input  ADDR_W  PC of resolving branch
res_branch  input  3  branch type code
res_zero  input  1  ALU zero flag
res_overflow  input  1  ALU overflow flag
res_negative  input  1  ALU negative flag
res_pred_taken  input  1  prediction that was used for this branch
res_target  input  ADDR_W  taken target
res_fallthrough  input  ADDR_W  not-taken PC
pcsrc  output  1  registered taken decision
redirect  output  1  one-cycle mispredict pulse
redirect_pc  output  ADDR_W  corrected PC, valid while redirect=1
branch_count  output  CNT_W  resolved branches, saturating
mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (rst=1 at clk edge): pcsrc=0, redirect=0, redirect_pc=0, both counters=0, every BHT entry=INIT_STATE. Reset mid-operation drops any pending redirect.
- Branch codes and taken conditions:
  - 000 NONE: never taken.
  - 001 BEQ: zero & ~overflow.
  - 010 BNE: ~zero.
  - 011 BGE: zero | ~negative.
  - 100 BLE: zero | negative.
  - 101 BGT: ~zero & ~negative.
  - 110 BLT: ~zero & negative.
  - 111 JMP: always taken.
- Index: idx = pc[log2(BHT_DEPTH)+1 : 2], using word-aligned PCs.
- Prediction:
  - pred_taken = pred_valid & BHT[idx(pred_pc)][1]. Zero-cycle path; no state change.
  - pred_valid=0 forces pred_taken=0.
- Resolution (res_valid=1 and res_branch!=000), sampled at edge N; outputs appear after edge N, 1-cycle latency:
  - pcsrc = taken.
  - redirect = (taken != res_pred_taken).
  - redirect_pc = taken ? res_target : res_fallthrough. redirect_pc is held at its last value when redirect=0.
  - BHT[idx(res_pc)] saturating update: +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
  - branch_count += 1; mispredict_count += 1 if mispredict. Both stick at all-ones.
- res_valid=0, or res_branch=000: pcsrc=0 and redirect=0 next cycle; no BHT update; no count.
- Back-to-back resolves every cycle are supported. Consecutive mispredicts give redirect high on consecutive cycles, each with its own redirect_pc.
- Same-cycle read/write to the same index: the prediction returns the pre-update value; the update is visible from the next cycle. No bypass.
- redirect is never high for more than one cycle per resolve.

Decomposition:
- Shared package branch_pkg:
  - 3-bit branch-type localparams (BR_NONE..BR_JMP).
  - 2-bit counter constants (SNT=00, WNT=01, WT=10, ST=11).
  - Pure function br_taken(type, zero, overflow, negative).
- One sub-module, bht_table: BHT_DEPTH x 2-bit register array with synchronous reset to INIT_STATE, one combinational read port, and one saturating-update write port.
- Top level holds condition evaluation, output registers and statistics.

Test Plan:
- Reset, then pred_valid=1, pred_pc=0x100 -> pred_taken=0; counters=0; pcsrc=0; redirect=0.
- Resolve BEQ at res_pc=0x100, zero=1, overflow=0, res_pred_taken=0, target=0x200, fallthrough=0x104 -> next cycle pcsrc=1, redirect=1, redirect_pc=0x200, branch_count=1, mispredict_count=1.
- Two more taken resolves at 0x100 -> entry reaches 11, pred_taken=1 for pred_pc=0x100. Four not-taken BNE resolves (zero=1) -> entry saturates at 00, pred_taken=0.
- Back-to-back cycles:
  - BGT with zero=0, negative=0, predicted 1 -> pcsrc=1, redirect=0.
  - BLT with negative=1, zero=1, predicted 1 -> pcsrc=0, redirect=1, redirect_pc=fallthrough.
- Same cycle, pred_pc=res_pc=0x40, entry=01, taken resolve -> pred_taken=0 that cycle, 1 the next cycle.
- CNT_W=4: 20 resolves of res_branch=000 leave branch_count=0. 20 JMP resolves with res_pred_taken=0 -> branch_count=15, mispredict_count=15. Asserting rst while redirect is pending -> redirect=0 and counters=0 next cycle.
